seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; generalises the fixed-pattern FSM detector.
- Pattern width and pattern are set by parameter; the pattern can also be reloaded at run time.
- Input is qualified by a valid strobe; overlapping or non-overlapping matching is selectable at run time.
- Optional saturating match counter. Sits on a serial line monitor, sampling one bit per clk.

Parameters:
- PATTERN_W, 4, pattern length in bits (legal range 2..32).
- PATTERN_RST, 4'b1011, pattern register value after reset. MSB is the first bit received.
- CNT_W, 8, match counter width (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset_i  input  1  synchronous reset, active-high.
- in_valid_i  input  1  in_i is sampled only when high.
- in_i  input  1  serial data bit.
- overlap_i  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- pattern_load_i  input  1  load pattern_i into the pattern register.
- pattern_i  input  PATTERN_W  new pattern; MSB is matched first.
- detected_o  output  1  one-cycle match pulse.
- armed_o  output  1  high when history holds PATTERN_W valid bits.
- match_count_o  output  CNT_W  saturating match count (optional feature).

Behaviour:
- Reset (reset_i=1 at posedge), which overrides every other input:
  - pattern_q <= PATTERN_RST; shift history <= 0; fill counter <= 0.
  - detected_o=0, armed_o=0, match_count_o=0.
- Reset mid-sequence discards every partially received bit.
- State is a fill counter with states EMPTY (0) through FULL (PATTERN_W). The counter increments on each accepted bit and saturates at PATTERN_W.
- armed_o = (fill == PATTERN_W), registered.
- Accepted bit: in_valid_i=1 and pattern_load_i=0. Then history <= {history[PATTERN_W-2:0], in_i}.
- Match condition, evaluated on the next-state values: next_history == pattern_q and next_fill == PATTERN_W.
- A history of all zeros at reset must never produce a match. Pattern 0000 therefore needs 4 real zeros after reset.
- detected_o is registered. It goes high the cycle after the edge that accepts the final pattern bit (1-cycle latency) and stays high for exactly one cycle unless the next accepted bit also matches.
- in_valid_i=0: history and fill are held, and detected_o returns to 0. Gaps in valid do not break a sequence.
- overlap_i=1: after a match, fill stays FULL, so back-to-back matches are possible. Pattern 1111 with a continuous stream of 1s gives a pulse every cycle.
- overlap_i=0: on a match, fill is cleared to 0, so the next match needs PATTERN_W fresh bits.
- overlap_i is sampled in the match cycle itself.
- pattern_load_i=1:
  - pattern_q <= pattern_i; fill <= 0; detected_o <= 0.
  - in_i is ignored that cycle even if in_valid_i=1.
  - Load wins over data.

Optional Feature:
- Macro SEQ_DET_COUNT_EN.
- Defined: match_count_o increments by 1 on every cycle in which detected_o is set, saturating at 2^CNT_W-1. It is cleared only by reset; pattern load does not clear it.
- Undefined: the counter logic is absent and match_count_o is tied to 0. The port still exists.

Test Plan:
- Reset, default pattern 1011, overlap_i=1, stream 1,0,1,1 with valid every cycle -> detected_o=1 for exactly one cycle, one cycle after the 4th bit; armed_o=1 from the 4th bit onward.
- Stream 1,0,1,1,0,1,1: with overlap_i=1 -> two pulses, after bits 4 and 7. Repeat with overlap_i=0 -> one pulse only, after bit 4.
- Stream 1,0, then in_valid_i=0 for 3 cycles with in_i=0, then 1,1 -> one detection after the final 1; no pulse during the gap.
- Feed 1,0,1, assert reset_i for 1 cycle, then feed 1 -> no detection; armed_o=0.
- Load pattern 0000 via pattern_load_i with in_valid_i=1 and in_i=0 on the load cycle -> that bit is ignored; the next three 0s give no detect; the fourth 0 detects.
- With SEQ_DET_COUNT_EN defined and CNT_W=2, overlap_i=1, stream of 8 consecutive 1s with pattern 1111 -> 5 pulses; match_count_o saturates at 3. Without the macro -> match_count_o stays 0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime pattern reload and overlap select.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param #(
  parameter int                   PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0] PATTERN_RST = 4'b1011,
  parameter int                   CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  input  logic                 in_i,
  input  logic                 overlap_i,
  input  logic                 pattern_load_i,
  input  logic [PATTERN_W-1:0] pattern_i,
  output logic                 detected_o,
  output logic                 armed_o,
  output logic [CNT_W-1:0]     match_count_o
);

  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

  function automatic logic [FILL_W-1:0] sat_inc_fill(input logic [FILL_W-1:0] v);
    if (v == FILL_FULL) return v;
    else                return v + FILL_W'(1);
  endfunction

  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [PATTERN_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 det_q, det_d;
  logic                 armed_q, armed_d;

  // Match is judged on next-state history/fill so the pulse lands one cycle after the final bit.
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    det_d     = 1'b0;
    if (pattern_load_i) begin
      pattern_d = pattern_i;
      fill_d    = '0;
    end else if (in_valid_i) begin
      hist_d = {hist_q[PATTERN_W-2:0], in_i};
      fill_d = sat_inc_fill(fill_q);
      det_d  = (hist_d == pattern_q) && (fill_d == FILL_FULL);
      if (det_d && !overlap_i) fill_d = '0;
    end
    armed_d = (fill_d == FILL_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      pattern_q <= PATTERN_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
      armed_q   <= armed_d;
    end
  end

  assign detected_o = det_q;
  assign armed_o    = armed_q;

`ifdef SEQ_DET_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts alongside the detect register so the count and pulse update on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (det_d) cnt_d = sat_inc_cnt(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign match_count_o = cnt_q;
`else
  assign match_count_o = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param against a bit-queue reference model.
// Counter expectations follow SEQ_DET_COUNT_EN.
module tb_seq_detector_param;

  localparam int PW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          in_valid_i = 1'b0;
  logic          in_i = 1'b0;
  logic          overlap_i = 1'b1;
  logic          pattern_load_i = 1'b0;
  logic [PW-1:0] pattern_i = '0;
  logic          detected_o;
  logic          armed_o;
  logic [CW-1:0] match_count_o;

  seq_detector_param #(.PATTERN_W(PW), .PATTERN_RST(4'b1011), .CNT_W(CW)) dut (
    .clk(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_i(in_i),
    .overlap_i(overlap_i), .pattern_load_i(pattern_load_i), .pattern_i(pattern_i),
    .detected_o(detected_o), .armed_o(armed_o), .match_count_o(match_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Reference model: bits accepted since the last clear, plus the active pattern.
  bit          mq[$];
  logic [PW-1:0] m_pat;
  logic        m_det;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int last_bits();
    int v = 0;
    for (int i = 0; i < mq.size(); i++) v = (v << 1) | int'(mq[i]);
    return v;
  endfunction

  task automatic step(input logic v, input logic b, input logic ov, input logic ld,
                      input logic [PW-1:0] p, input logic r);
    @(negedge clk);
    reset_i = r; in_valid_i = v; in_i = b; overlap_i = ov; pattern_load_i = ld; pattern_i = p;
    @(posedge clk);
    if (r) begin
      m_pat = 4'b1011; mq.delete(); m_det = 1'b0; m_cnt = 0;
    end else if (ld) begin
      m_pat = p; mq.delete(); m_det = 1'b0;
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > PW) void'(mq.pop_front());
      m_det = (mq.size() == PW) && (last_bits() == int'(m_pat));
      if (m_det) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (!ov) mq.delete();
      end
    end else begin
      m_det = 1'b0;
    end
    #1;
    check_eq("detected", 32'(detected_o), 32'(m_det));
    check_eq("armed", 32'(armed_o), 32'(mq.size() == PW));
`ifdef SEQ_DET_COUNT_EN
    check_eq("count", 32'(match_count_o), 32'(m_cnt));
`else
    check_eq("count", 32'(match_count_o), 32'd0);
`endif
    if (detected_o) pulses++;
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    do_reset();
    check_eq("rst_det", 32'(detected_o), 32'd0);
    check_eq("rst_armed", 32'(armed_o), 32'd0);
    check_eq("rst_cnt", 32'(match_count_o), 32'd0);

    // Basic match, overlap on.
    pulses = 0;
    feed(16'b1011, 4, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check_eq("basic_pulses", 32'(pulses), 32'd1);

    // 1011011 with and without overlap.
    do_reset(); pulses = 0;
    feed(16'b1011011, 7, 1'b1);
    check_eq("ov_pulses", 32'(pulses), 32'd2);
    do_reset(); pulses = 0;
    feed(16'b1011011, 7, 1'b0);
    check_eq("nov_pulses", 32'(pulses), 32'd1);

    // Valid gap does not break a sequence.
    do_reset(); pulses = 0;
    feed(16'b10, 2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check_eq("gap_pulses", 32'(pulses), 32'd0);
    feed(16'b11, 2, 1'b1);
    check_eq("gap_pulses_end", 32'(pulses), 32'd1);

    // Reset mid-sequence.
    do_reset(); pulses = 0;
    feed(16'b101, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    feed(16'b1, 1, 1'b1);
    check_eq("midrst_pulses", 32'(pulses), 32'd0);
    check_eq("midrst_armed", 32'(armed_o), 32'd0);

    // Load 0000 with a valid zero on the load cycle.
    do_reset(); pulses = 0;
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    feed(16'b000, 3, 1'b1);
    check_eq("load0_early", 32'(pulses), 32'd0);
    feed(16'b0, 1, 1'b1);
    check_eq("load0_hit", 32'(pulses), 32'd1);

    // Pattern 1111 with eight ones: five pulses, counter saturates.
    do_reset(); pulses = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
    feed(16'hFF, 8, 1'b1);
    check_eq("ones_pulses", 32'(pulses), 32'd5);
`ifdef SEQ_DET_COUNT_EN
    check_eq("ones_sat", 32'(match_count_o), 32'd3);
`else
    check_eq("ones_sat", 32'(match_count_o), 32'd0);
`endif

    // Random traffic with occasional loads and resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rv, rb, rov, rld, rr;
      logic [PW-1:0] rp;
      rv  = ($urandom_range(0, 3) != 0);
      rb  = 1'($urandom);
      rov = ($urandom_range(0, 7) != 0) ? overlap_i : 1'($urandom);
      rld = ($urandom_range(0, 60) == 0);
      rp  = PW'($urandom);
      rr  = ($urandom_range(0, 150) == 0);
      step(rv, rb, rov, rld, rp, rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
